// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the moving-sum filter pair (forward filter and
// inverse). Holds the default geometry, the largest legal moving-sum value
// and the inverse-filter state encoding.
package fir_pkg;

    localparam int unsigned N_DEF    = 4;   // taps of the forward moving sum
    localparam int unsigned W_IN_DEF = 8;   // raw sample width
    localparam int unsigned W_Y_DEF  = 16;  // moving-sum width

    // Largest value a consistent n-tap moving sum of w-bit samples can take.
    function automatic int unsigned y_max(input int unsigned n, input int unsigned w);
        return n * ((32'd1 << w) - 32'd1);
    endfunction

    localparam int unsigned YMAX = y_max(N_DEF, W_IN_DEF);

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } fir_state_t;

endpackage

// File: rtl/fir_inverse_sample_history.sv
// sample_history
// N-deep shift register of reconstructed samples. The oldest entry (tap N-1)
// is the x[n-N] term of the inverse recursion.
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset (flushes history)
//   clear     synchronous history flush
//   shift_en  push din into slot 0, shift everything one slot older
//   din       newest reconstructed sample
//   tap       oldest stored sample, x[n-N]
module sample_history #(
    parameter int unsigned N    = fir_pkg::N_DEF,
    parameter int unsigned W_IN = fir_pkg::W_IN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            shift_en,
    input  logic [W_IN-1:0] din,
    output logic [W_IN-1:0] tap
);

    logic [W_IN-1:0] hist [N];

    // NOTE: this storage is reset on purpose; the recursion assumes all past
    // samples are zero, so stale contents would corrupt every later output.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < N; i++) hist[i] <= '0;
        end else if (shift_en) begin
            hist[0] <= din;
            for (int i = 1; i < N; i++) hist[i] <= hist[i-1];
        end
    end

    assign tap = hist[N-1];

endmodule

// File: rtl/fir_inverse.sv
// fir_inverse
// Recovers raw samples x[n] from an N-tap unity-coefficient moving sum
// y[n] = x[n] + ... + x[n-N+1] via x[n] = y[n] - y[n-1] + x[n-N].
// A sample that cannot belong to a valid moving sum drops the block into
// an error state (sticky sync_err) until clear.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   clear      synchronous history flush and error clear
//   in_valid   y_in valid
//   in_ready   block can take y_in this cycle
//   y_in       moving-sum sample y[n]
//   out_valid  x_out holds a reconstructed sample
//   out_ready  downstream takes x_out
//   x_out      reconstructed sample x[n]
//   sync_err   sticky stream-inconsistency flag
module fir_inverse
    import fir_pkg::*;
#(
    parameter int unsigned N    = fir_pkg::N_DEF,
    parameter int unsigned W_IN = fir_pkg::W_IN_DEF,
    parameter int unsigned W_Y  = fir_pkg::W_Y_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W_Y-1:0]  y_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W_IN-1:0] x_out,
    output logic            sync_err
);

    localparam int unsigned          Y_MAX_I = y_max(N, W_IN);
    localparam logic [W_Y-1:0]       Y_MAX_V = Y_MAX_I[W_Y-1:0];
    localparam logic signed [W_Y+1:0] X_MAX  = (W_Y+2)'((1 << W_IN) - 1);

    fir_state_t            state_q, state_d;
    logic [W_Y-1:0]        y_prev;
    logic [W_IN-1:0]       hist_tap;
    logic signed [W_Y+1:0] d;
    logic                  accept;
    logic                  consistent;
    logic                  take_sample;

    // Two extra bits: one for the sign of y_in - y_prev, one for the carry
    // from adding x[n-N].
    assign d = $signed({2'b00, y_in}) - $signed({2'b00, y_prev})
             + $signed({{(W_Y+2-W_IN){1'b0}}, hist_tap});

    assign consistent = !d[W_Y+1] && (d <= X_MAX) && (y_in <= Y_MAX_V);

    // No skid buffer: accept only when the output slot is free or being
    // drained this cycle. In ERR nothing is produced, so input always flows.
    assign in_ready = !reset && !clear &&
                      ((state_q == ERR) || !out_valid || out_ready);

    assign accept      = in_valid && in_ready;
    assign take_sample = accept && (state_q == RUN) && consistent;

    // NOTE: every output of this block gets a default first so no path
    // leaves state_d unassigned and a latch cannot be inferred.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = RUN;
        end else if (state_q == RUN && accept && !consistent) begin
            state_d = ERR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            out_valid <= 1'b0;
            x_out     <= '0;
            sync_err  <= 1'b0;
            y_prev    <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                out_valid <= 1'b0;
                sync_err  <= 1'b0;
                y_prev    <= '0;
            end else if (state_q == RUN) begin
                if (take_sample) begin
                    x_out     <= d[W_IN-1:0];
                    out_valid <= 1'b1;
                    y_prev    <= y_in;
                end else if (accept) begin
                    // Inconsistent sample: discard, keep history and y_prev.
                    out_valid <= 1'b0;
                    sync_err  <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    sample_history #(
        .N    (N),
        .W_IN (W_IN)
    ) u_history (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .shift_en (take_sample),
        .din      (d[W_IN-1:0]),
        .tap      (hist_tap)
    );

endmodule
